// File: rtl/exp_align_sched_pkg.sv
// Shared types and constants for the block-floating-point
// exponent alignment scheduler.
package exp_align_sched_pkg;

  localparam int LANES          = 2;
  localparam int ZERO_SHIFT_DEF = 9;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_e;

endpackage

// File: rtl/exp_lane_offset.sv
// Per-lane alignment offset: distance from the block max,
// with zero exponents pushed fully out of range.
module exp_lane_offset #(
  parameter int EXP_W      = 4,
  parameter int ZERO_SHIFT = 9
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [EXP_W-1:0] max_i,
  output logic [EXP_W-1:0] offset_o
);

  assign offset_o = (exp_i == '0) ? EXP_W'(ZERO_SHIFT)
                                  : max_i - exp_i;

endmodule

// File: rtl/exp_align_sched.sv
// Collects a block of exponent pairs, tracks the block max,
// then replays the block as per-lane right-shift offsets.
module exp_align_sched
  import exp_align_sched_pkg::*;
#(
  parameter int EXP_W      = 4,
  parameter int DEPTH      = 8,
  parameter int ZERO_SHIFT = ZERO_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*EXP_W-1:0]   in_exp,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*EXP_W-1:0]   out_offset,
  output logic [EXP_W-1:0]         out_max_exp,
  output logic                     out_last,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = LANES * EXP_W;

  state_e state_q, state_d;

  logic [BW-1:0]    mem_q [DEPTH];
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic [EXP_W-1:0] max_q, max_d;
  logic [EXP_W-1:0] omax_q, omax_d;
  logic [BW-1:0]    off_q, off_d;
  logic             ov_q, ov_d;
  logic             ol_q, ol_d;
  logic             rdy_q, rdy_d;

  logic             in_fire;
  logic             out_fire;
  logic             wr_en;
  logic [EXP_W-1:0] beat_max;
  logic [BW-1:0]    rd_data;
  logic [BW-1:0]    rd_off;
  logic [CW-1:0]    rcnt_n;

  assign in_fire  = in_valid & rdy_q;
  assign out_fire = ov_q & out_ready;
  assign rd_data  = mem_q[rcnt_q[AW-1:0]];
  assign rcnt_n   = rcnt_q + CW'(1);

  always_comb begin
    beat_max = max_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_exp[i*EXP_W +: EXP_W] > beat_max)
        beat_max = in_exp[i*EXP_W +: EXP_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exp_lane_offset #(
      .EXP_W     (EXP_W),
      .ZERO_SHIFT(ZERO_SHIFT)
    ) u_off (
      .exp_i   (rd_data[g*EXP_W +: EXP_W]),
      .max_i   (omax_q),
      .offset_o(rd_off[g*EXP_W +: EXP_W])
    );
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    max_d   = max_q;
    omax_d  = omax_q;
    off_d   = off_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (in_fire) begin
          wr_en   = 1'b1;
          wcnt_d  = wcnt_q + CW'(1);
          max_d   = beat_max;
          state_d = COLLECT;
          // in_last is irrelevant once the buffer is full
          if (in_last || wcnt_q == CW'(DEPTH-1)) begin
            state_d = EMIT;
            omax_d  = beat_max;
          end
        end
      end
      EMIT: begin
        if (out_fire) ov_d = 1'b0;
        if ((!ov_q || out_ready) && rcnt_q != wcnt_q) begin
          ov_d   = 1'b1;
          off_d  = rd_off;
          ol_d   = (rcnt_n == wcnt_q);
          rcnt_d = rcnt_n;
        end
        if (out_fire && ol_q) begin
          state_d = IDLE;
          wcnt_d  = '0;
          rcnt_d  = '0;
          max_d   = '0;
          ol_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d != EMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      max_q   <= '0;
      omax_q  <= '0;
      off_q   <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      max_q   <= max_d;
      omax_q  <= omax_d;
      off_q   <= off_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wcnt_q[AW-1:0]] <= in_exp;
  end

  assign in_ready    = rdy_q;
  assign out_valid   = ov_q;
  assign out_offset  = off_q;
  assign out_last    = ol_q;
  assign out_max_exp = omax_q;
  assign busy        = (state_q != IDLE);

endmodule
